// File: rtl/fir_out_monitor.sv
// Capture monitor for a FIR output stream. It takes DEPTH samples after an accepted start,
// keeps a count, a running peak and a 16-bit MISR signature, and then drains the samples in order.
module fir_out_monitor #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     sample_count,
    output logic [15:0]                signature,
    output logic [DATA_W-1:0]          peak,
    output logic                       rd_valid,
    output logic [DATA_W-1:0]          rd_data,
    input  logic                       rd_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic [15:0]         sig_q, sig_d;
    logic [DATA_W-1:0]   peak_q, peak_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                rd_valid_q, rd_valid_d;
    logic                wr_en_d;
    logic [AW-1:0]       wr_addr_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    // One MISR step: shift with feedback taps 15/13/12/10, then fold in the zero-extended sample.
    function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [DATA_W-1:0] d);
        logic fb;
        fb = sig[15] ^ sig[13] ^ sig[12] ^ sig[10];
        return {sig[14:0], fb} ^ 16'(d);
    endfunction

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        sig_d      = sig_q;
        peak_d     = peak_q;
        rd_ptr_d   = rd_ptr_q;
        done_d     = 1'b0;
        wr_en_d    = 1'b0;
        wr_addr_d  = count_q[AW-1:0];
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_CAPTURE;
                    count_d  = {CW{1'b0}};
                    sig_d    = 16'hFFFF;
                    peak_d   = {DATA_W{1'b0}};
                    rd_ptr_d = {AW{1'b0}};
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (in_valid) begin
                    wr_en_d = 1'b1;
                    count_d = count_q + CW'(1);
                    sig_d   = misr_step(sig_q, in_data);
                    if (in_data > peak_q) begin
                        peak_d = in_data;
                    end else begin
                        peak_d = peak_q;
                    end
                    // The edge accepting the last sample hands over to DRAIN.
                    if (count_q == CW'(DEPTH - 1)) begin
                        state_d = ST_DRAIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_CAPTURE;
                    end
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_DRAIN: begin
                if (rd_ready) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    if (rd_ptr_q == AW'(DEPTH - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    rd_ptr_d = rd_ptr_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d     = (state_d != ST_IDLE);
        rd_valid_d = (state_d == ST_DRAIN);
    end

    // Control and status registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            count_q    <= {CW{1'b0}};
            sig_q      <= 16'hFFFF;
            peak_q     <= {DATA_W{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            sig_q      <= sig_d;
            peak_q     <= peak_d;
            rd_ptr_q   <= rd_ptr_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Sample buffer; contents are left as-is on reset.
    always_ff @(posedge clk) begin
        if (wr_en_d && !rst) begin
            mem_q[wr_addr_d] <= in_data;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign sample_count = count_q;
    assign signature    = sig_q;
    assign peak         = peak_q;
    assign rd_valid     = rd_valid_q;
    assign rd_data      = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_fir_out_monitor.sv
// Randomised scoreboard bench for fir_out_monitor: stimulus pushes captured samples into a queue,
// a negedge monitor pops and compares on every drain transfer.
module tb_fir_out_monitor;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        busy;
    logic        done;
    logic [4:0]  sample_count;
    logic [15:0] signature;
    logic [7:0]  peak;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        rd_ready;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    logic [7:0]  exp_q [$];
    logic [7:0]  stim [16];

    fir_out_monitor #(.DATA_W(8), .DEPTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .busy         (busy),
        .done         (done),
        .sample_count (sample_count),
        .signature    (signature),
        .peak         (peak),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_ready     (rd_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] misr_ref(input logic [15:0] s, input logic [7:0] d);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return ((s << 1) | 16'(fb)) ^ {8'h00, d};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every drain cycle must present the oldest outstanding sample.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) done_cnt++;
        if (!rst && rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rd: got %0h expected no data", rd_data);
            end else begin
                check("rd_data", {24'h0, rd_data}, {24'h0, exp_q[0]});
                if (rd_ready) void'(exp_q.pop_front());
            end
        end
    end

    // gap: 0 contiguous, 1 every other cycle. stall: 0 ready, 1 five-cycle hold, 2 random ready.
    task automatic run_op(input int gap, input int stall, input bit poke_start, input string tag);
        int          i;
        int          cyc;
        int          stalled;
        logic [15:0] m_sig;
        logic [7:0]  m_peak;
        done_cnt = 0;
        start = 1'b1; in_valid = 1'b1; in_data = 8'hDD;
        tick;
        start = 1'b0; in_valid = 1'b0;
        check({tag, " arm busy"}, {31'h0, busy}, 32'd1);
        check({tag, " arm count"}, {27'h0, sample_count}, 32'd0);
        check({tag, " arm sig"}, {16'h0, signature}, 32'hFFFF);
        check({tag, " arm peak"}, {24'h0, peak}, 32'd0);
        m_sig = 16'hFFFF; m_peak = 8'h00; i = 0; cyc = 0;
        while (i < 16 && cyc < 200) begin
            in_valid = (gap == 0) ? 1'b1 : ((cyc % 2) == 1);
            start    = poke_start && (i == 3) && in_valid;
            if (in_valid) begin
                in_data = stim[i];
                exp_q.push_back(stim[i]);
                m_sig = misr_ref(m_sig, stim[i]);
                if (stim[i] > m_peak) m_peak = stim[i];
                i++;
            end else begin
                in_data = 8'($urandom);
            end
            tick;
            cyc++;
        end
        in_valid = 1'b0; start = 1'b0;
        check({tag, " capture finished"}, i, 16);
        check({tag, " done pulse"}, {31'h0, done}, 32'd1);
        check({tag, " rd_valid latency"}, {31'h0, rd_valid}, 32'd1);
        check({tag, " count"}, {27'h0, sample_count}, 32'd16);
        check({tag, " peak"}, {24'h0, peak}, {24'h0, m_peak});
        check({tag, " sig"}, {16'h0, signature}, {16'h0, m_sig});
        cyc = 0; stalled = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            if (stall == 1 && exp_q.size() == 8 && stalled < 5) begin
                rd_ready = 1'b0;
                stalled++;
            end else if (stall == 2) begin
                rd_ready = 1'($urandom_range(0, 1));
            end else begin
                rd_ready = 1'b1;
            end
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            start    = poke_start && (cyc == 2);
            tick;
            cyc++;
        end
        rd_ready = 1'b0; in_valid = 1'b0; start = 1'b0;
        check({tag, " drain finished"}, exp_q.size(), 0);
        exp_q.delete();
        check({tag, " idle busy"}, {31'h0, busy}, 32'd0);
        check({tag, " idle rd_valid"}, {31'h0, rd_valid}, 32'd0);
        check({tag, " done count"}, done_cnt, 1);
        in_valid = 1'b1; in_data = 8'hFF;
        tick;
        in_valid = 1'b0;
        check({tag, " held count"}, {27'h0, sample_count}, 32'd16);
        check({tag, " held peak"}, {24'h0, peak}, {24'h0, m_peak});
        check({tag, " held sig"}, {16'h0, signature}, {16'h0, m_sig});
        check({tag, " still idle"}, {31'h0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; rd_ready = 1'b0;
        tick; tick;
        check("reset busy", {31'h0, busy}, 32'd0);
        check("reset rd_valid", {31'h0, rd_valid}, 32'd0);
        check("reset done", {31'h0, done}, 32'd0);
        check("reset count", {27'h0, sample_count}, 32'd0);
        check("reset peak", {24'h0, peak}, 32'd0);
        check("reset sig", {16'h0, signature}, 32'hFFFF);
        rst = 1'b0;
        tick;

        for (int k = 0; k < 16; k++) stim[k] = 8'(k);
        run_op(0, 0, 1'b0, "ramp");

        for (int k = 0; k < 16; k++) stim[k] = 8'($urandom);
        run_op(1, 2, 1'b0, "gapped");

        for (int k = 0; k < 16; k++) stim[k] = 8'($urandom);
        run_op(0, 1, 1'b0, "backpressure");

        for (int k = 0; k < 16; k++) stim[k] = 8'($urandom);
        run_op(1, 0, 1'b1, "ignored_start");

        start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            tick;
        end
        in_valid = 1'b0;
        check("mid count", {27'h0, sample_count}, 32'd7);
        rst = 1'b1; start = 1'b1; in_valid = 1'b1;
        tick;
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        check("midrst busy", {31'h0, busy}, 32'd0);
        check("midrst count", {27'h0, sample_count}, 32'd0);
        check("midrst sig", {16'h0, signature}, 32'hFFFF);
        check("midrst peak", {24'h0, peak}, 32'd0);
        check("midrst rd_valid", {31'h0, rd_valid}, 32'd0);
        for (int k = 0; k < 16; k++) stim[k] = 8'hA5;
        run_op(0, 0, 1'b0, "a5_restart");

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 16; k++) stim[k] = 8'($urandom);
            run_op(int'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
